// File: rtl/adc_sample_fifo.sv
// Elastic FWFT buffer between the ADC sample stream and a valid/ready consumer.
// Define ADC_FIFO_DROP_CNT_EN to build the saturating dropped-sample counter.
module adc_sample_fifo #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ALMOST_FULL = 12,
    parameter int unsigned DROP_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       clear_ovf,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              almost_full_q, almost_full_d;
    logic              overflow_q, overflow_d;

    logic full, push, pop, drop;

    always_comb begin
        full = (level_q == LVL_W'(DEPTH));
        pop  = out_valid_q & out_ready;
        push = in_valid & (~full | pop);
        drop = in_valid & full & ~pop;
    end

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d       = level_q + LVL_W'(push) - LVL_W'(pop);
        out_valid_d   = (level_d != '0);
        almost_full_d = (level_d >= LVL_W'(ALMOST_FULL));
        // New head is the incoming sample when nothing else remains after this cycle's pop.
        out_data_d    = out_data_q;
        if (push && (level_q - LVL_W'(pop)) == '0) begin
            out_data_d = in_data;
        end else if (level_d != '0) begin
            out_data_d = mem[rd_ptr_d];
        end
        // A drop in the same cycle as a clear keeps the flag set.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef ADC_FIFO_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf) begin
            drop_cnt_d = DROP_W'(drop);
        end else if (drop && drop_cnt_q != {DROP_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign level       = level_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Scoreboard bench for adc_sample_fifo; expected samples queued on acceptance, checked on pop.
// Honours ADC_FIFO_DROP_CNT_EN for the drop counter expectations.
module tb_adc_sample_fifo;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AF     = 12;
    localparam int unsigned DROP_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        level;
    logic              almost_full;
    logic              overflow;
    logic              clear_ovf;
    logic [DROP_W-1:0] drop_cnt;

    adc_sample_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ALMOST_FULL(AF),
        .DROP_W     (DROP_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .almost_full(almost_full),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] sb_q[$];
    int                m_level = 0;
    logic              m_ovf   = 1'b0;
    int                m_drop  = 0;
    logic [DATA_W-1:0] seq     = 16'h0001;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".level"}, 32'(level), 32'(m_level));
        check_eq({tag, ".afull"}, 32'(almost_full), 32'(m_level >= AF));
        check_eq({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef ADC_FIFO_DROP_CNT_EN
        check_eq({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
`else
        check_eq({tag, ".drop"}, 32'(drop_cnt), 32'd0);
`endif
    endtask

    // One clock: drive, score any pop, advance model, clock, check registered state.
    task automatic cyc(input string tag, input logic v, input logic rdy, input logic clr);
        logic pop, push, drop;
        in_valid  = v;
        in_data   = seq;
        out_ready = rdy;
        clear_ovf = clr;
        #1;
        check_eq({tag, ".ovalid"}, 32'(out_valid), 32'(m_level != 0));
        pop  = (m_level != 0) && rdy;
        push = v && (m_level < DEPTH || pop);
        drop = v && (m_level == DEPTH) && !pop;
        if (pop) begin
            check_eq({tag, ".odata"}, 32'(out_data), 32'(sb_q.pop_front()));
        end
        if (push) sb_q.push_back(seq);
        if (v) seq = seq + 16'h0001;
        m_level = m_level + int'(push) - int'(pop);
        if (clr) m_drop = drop ? 1 : 0;
        else if (drop && m_drop < 65535) m_drop++;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_ovf = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        clear_ovf = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_drop  = 0;
        check_eq("rst.ovalid", 32'(out_valid), 32'd0);
        check_eq("rst.odata", 32'(out_data), 32'd0);
        check_state("rst");
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && m_level != 0; i++) cyc(tag, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: streaming with consumer always ready
        for (int i = 0; i < 5; i++) cyc("t1", 1'b1, 1'b1, 1'b0);
        cyc("t1", 1'b0, 1'b1, 1'b0);
        check_eq("t1.empty", 32'(out_valid), 32'd0);

        // 2: fill to almost-full threshold
        for (int i = 0; i < 12; i++) cyc("t2", 1'b1, 1'b0, 1'b0);
        check_eq("t2.afull_hi", 32'(almost_full), 32'd1);
        drain("t2d");

        // 3: overfill by three
        for (int i = 0; i < DEPTH + 3; i++) cyc("t3", 1'b1, 1'b0, 1'b0);
        check_eq("t3.ovf_set", 32'(overflow), 32'd1);
        drain("t3d");
        cyc("t3c", 1'b0, 1'b0, 1'b1);

        // 4: full, push and pop together
        for (int i = 0; i < DEPTH; i++) cyc("t4f", 1'b1, 1'b0, 1'b0);
        cyc("t4", 1'b1, 1'b1, 1'b0);
        check_eq("t4.level16", 32'(level), 32'd16);

        // 5: drop coincident with clear, then plain clear
        cyc("t5a", 1'b1, 1'b0, 1'b0);
        cyc("t5b", 1'b1, 1'b0, 1'b1);
        check_eq("t5.ovf_kept", 32'(overflow), 32'd1);
        cyc("t5c", 1'b0, 1'b0, 1'b1);
        drain("t5d");

        // 6: reset mid-operation
        for (int i = 0; i < 7; i++) cyc("t6f", 1'b1, 1'b0, 1'b0);
        do_reset();
        cyc("t6", 1'b1, 1'b0, 1'b0);
        check_eq("t6.ovalid_after", 32'(out_valid), 32'd1);
        cyc("t6p", 1'b0, 1'b1, 1'b0);
        check_eq("t6.sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
